// File: rtl/nmea_gga_parser.sv
// NMEA-0183 $GPGGA parser that pops bytes from a UART receive FIFO.
// Fields collect in working registers. They reach the outputs only when the checksum matches.
module nmea_gga_parser #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned MAX_LEN   = 82
) (
  input  logic                 clk_50MHz,
  input  logic                 reset,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_rd_data,
  output logic                 fifo_rd,
  output logic [23:0]          utc_time,
  output logic [31:0]          lat_bcd,
  output logic                 lat_south,
  output logic [35:0]          lon_bcd,
  output logic                 lon_west,
  output logic [3:0]           fix_quality,
  output logic [7:0]           num_sats,
  output logic                 sentence_valid,
  output logic                 checksum_err,
  output logic                 frame_err
);

  localparam int unsigned     LenW   = $clog2(MAX_LEN + 2);
  localparam logic [LenW-1:0] MaxLen = LenW'(MAX_LEN);

  typedef enum logic [2:0] {StIdle, StHdr, StFields, StCkHi, StCkLo} state_e;

  state_e          state_q, state_d;
  logic [2:0]      hdr_idx_q, hdr_idx_d;
  logic [3:0]      field_q, field_d;
  logic            dot_q, dot_d;
  logic [2:0]      frac_cnt_q, frac_cnt_d;
  logic [LenW-1:0] len_q, len_d, len_inc;
  logic [7:0]      xor_q, xor_d;
  logic [3:0]      ck_hi_q, ck_hi_d;

  logic [23:0] w_time_q, w_time_d;
  logic [15:0] w_lat_int_q, w_lat_int_d;
  logic [15:0] w_lat_frac_q, w_lat_frac_d;
  logic [19:0] w_lon_int_q, w_lon_int_d;
  logic [15:0] w_lon_frac_q, w_lon_frac_d;
  logic        w_south_q, w_south_d;
  logic        w_west_q, w_west_d;
  logic [3:0]  w_fix_q, w_fix_d;
  logic [7:0]  w_sats_q, w_sats_d;

  logic [23:0] utc_q, utc_d;
  logic [31:0] lat_q, lat_d;
  logic        south_q, south_d;
  logic [35:0] lon_q, lon_d;
  logic        west_q, west_d;
  logic [3:0]  fix_q, fix_d;
  logic [7:0]  sats_q, sats_d;
  logic        valid_q, valid_d;
  logic        ck_err_q, ck_err_d;
  logic        fr_err_q, fr_err_d;

  logic [7:0] ch;
  logic [7:0] hdr_char;
  logic       is_digit;
  logic       is_hex;
  logic [3:0] hex_nib;

  assign fifo_rd = ~fifo_empty & ~reset;
  assign ch      = fifo_rd_data[7:0];

  assign utc_time       = utc_q;
  assign lat_bcd        = lat_q;
  assign lat_south      = south_q;
  assign lon_bcd        = lon_q;
  assign lon_west       = west_q;
  assign fix_quality    = fix_q;
  assign num_sats       = sats_q;
  assign sentence_valid = valid_q;
  assign checksum_err   = ck_err_q;
  assign frame_err      = fr_err_q;

  // Place the pos-th fraction digit, most significant nibble first.
  function automatic logic [15:0] put_frac(input logic [15:0] frac, input logic [1:0] pos,
                                           input logic [3:0] nib);
    logic [15:0] r;
    r = frac;
    unique case (pos)
      2'd0:    r[15:12] = nib;
      2'd1:    r[11:8]  = nib;
      2'd2:    r[7:4]   = nib;
      default: r[3:0]   = nib;
    endcase
    return r;
  endfunction

  always_comb begin
    is_digit = (ch >= 8'h30) && (ch <= 8'h39);
    is_hex   = is_digit;
    hex_nib  = ch[3:0];
    if (((ch >= 8'h41) && (ch <= 8'h46)) || ((ch >= 8'h61) && (ch <= 8'h66))) begin
      is_hex  = 1'b1;
      hex_nib = ch[3:0] + 4'd9;
    end
  end

  always_comb begin
    case (hdr_idx_q)
      3'd1:    hdr_char = "P";
      3'd4:    hdr_char = "A";
      default: hdr_char = "G";
    endcase
  end

  always_comb begin
    state_d      = state_q;
    hdr_idx_d    = hdr_idx_q;
    field_d      = field_q;
    dot_d        = dot_q;
    frac_cnt_d   = frac_cnt_q;
    len_d        = len_q;
    xor_d        = xor_q;
    ck_hi_d      = ck_hi_q;
    w_time_d     = w_time_q;
    w_lat_int_d  = w_lat_int_q;
    w_lat_frac_d = w_lat_frac_q;
    w_lon_int_d  = w_lon_int_q;
    w_lon_frac_d = w_lon_frac_q;
    w_south_d    = w_south_q;
    w_west_d     = w_west_q;
    w_fix_d      = w_fix_q;
    w_sats_d     = w_sats_q;
    utc_d        = utc_q;
    lat_d        = lat_q;
    south_d      = south_q;
    lon_d        = lon_q;
    west_d       = west_q;
    fix_d        = fix_q;
    sats_d       = sats_q;
    valid_d      = 1'b0;
    ck_err_d     = 1'b0;
    fr_err_d     = 1'b0;
    len_inc      = len_q + LenW'(1);

    if (fifo_rd) begin
      if (ch == "$") begin
        // A '$' always restarts, even mid-sentence or inside the checksum.
        state_d      = StHdr;
        hdr_idx_d    = 3'd0;
        field_d      = 4'd0;
        dot_d        = 1'b0;
        frac_cnt_d   = 3'd0;
        len_d        = LenW'(1);
        xor_d        = 8'h00;
        w_time_d     = '0;
        w_lat_int_d  = '0;
        w_lat_frac_d = '0;
        w_lon_int_d  = '0;
        w_lon_frac_d = '0;
        w_south_d    = 1'b0;
        w_west_d     = 1'b0;
        w_fix_d      = '0;
        w_sats_d     = '0;
      end else begin
        unique case (state_q)
          StIdle: ;
          StHdr: begin
            if (ch == hdr_char) begin
              xor_d = xor_q ^ ch;
              len_d = len_inc;
              if (hdr_idx_q == 3'd4) begin
                state_d = StFields;
                field_d = 4'd0;
              end else begin
                hdr_idx_d = hdr_idx_q + 3'd1;
              end
            end else begin
              state_d = StIdle;
            end
          end
          StFields: begin
            len_d = len_inc;
            if (len_inc > MaxLen) begin
              fr_err_d = 1'b1;
              state_d  = StIdle;
            end else if (ch == "*") begin
              state_d = StCkHi;
            end else begin
              xor_d = xor_q ^ ch;
              if (ch == ",") begin
                field_d    = (field_q == 4'hF) ? field_q : field_q + 4'd1;
                dot_d      = 1'b0;
                frac_cnt_d = 3'd0;
              end else begin
                if (ch == ".") begin
                  dot_d = 1'b1;
                end
                case (field_q)
                  4'd1: if (is_digit && !dot_q) w_time_d = {w_time_q[19:0], ch[3:0]};
                  4'd2: begin
                    if (is_digit && !dot_q) begin
                      w_lat_int_d = {w_lat_int_q[11:0], ch[3:0]};
                    end else if (is_digit && (frac_cnt_q < 3'd4)) begin
                      w_lat_frac_d = put_frac(w_lat_frac_q, frac_cnt_q[1:0], ch[3:0]);
                      frac_cnt_d   = frac_cnt_q + 3'd1;
                    end
                  end
                  4'd3: w_south_d = (ch == "S");
                  4'd4: begin
                    if (is_digit && !dot_q) begin
                      w_lon_int_d = {w_lon_int_q[15:0], ch[3:0]};
                    end else if (is_digit && (frac_cnt_q < 3'd4)) begin
                      w_lon_frac_d = put_frac(w_lon_frac_q, frac_cnt_q[1:0], ch[3:0]);
                      frac_cnt_d   = frac_cnt_q + 3'd1;
                    end
                  end
                  4'd5: w_west_d = (ch == "W");
                  4'd6: if (is_digit) w_fix_d = ch[3:0];
                  4'd7: if (is_digit) w_sats_d = {w_sats_q[3:0], ch[3:0]};
                  default: ;
                endcase
              end
            end
          end
          StCkHi: begin
            if (is_hex) begin
              ck_hi_d = hex_nib;
              state_d = StCkLo;
            end else begin
              fr_err_d = 1'b1;
              state_d  = StIdle;
            end
          end
          StCkLo: begin
            state_d = StIdle;
            if (!is_hex) begin
              fr_err_d = 1'b1;
            end else if ({ck_hi_q, hex_nib} == xor_q) begin
              valid_d = 1'b1;
              utc_d   = w_time_q;
              lat_d   = {w_lat_int_q, w_lat_frac_q};
              south_d = w_south_q;
              lon_d   = {w_lon_int_q, w_lon_frac_q};
              west_d  = w_west_q;
              fix_d   = w_fix_q;
              sats_d  = w_sats_q;
            end else begin
              ck_err_d = 1'b1;
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      hdr_idx_q    <= '0;
      field_q      <= '0;
      dot_q        <= 1'b0;
      frac_cnt_q   <= '0;
      len_q        <= '0;
      xor_q        <= '0;
      ck_hi_q      <= '0;
      w_time_q     <= '0;
      w_lat_int_q  <= '0;
      w_lat_frac_q <= '0;
      w_lon_int_q  <= '0;
      w_lon_frac_q <= '0;
      w_south_q    <= 1'b0;
      w_west_q     <= 1'b0;
      w_fix_q      <= '0;
      w_sats_q     <= '0;
      utc_q        <= '0;
      lat_q        <= '0;
      south_q      <= 1'b0;
      lon_q        <= '0;
      west_q       <= 1'b0;
      fix_q        <= '0;
      sats_q       <= '0;
      valid_q      <= 1'b0;
      ck_err_q     <= 1'b0;
      fr_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      hdr_idx_q    <= hdr_idx_d;
      field_q      <= field_d;
      dot_q        <= dot_d;
      frac_cnt_q   <= frac_cnt_d;
      len_q        <= len_d;
      xor_q        <= xor_d;
      ck_hi_q      <= ck_hi_d;
      w_time_q     <= w_time_d;
      w_lat_int_q  <= w_lat_int_d;
      w_lat_frac_q <= w_lat_frac_d;
      w_lon_int_q  <= w_lon_int_d;
      w_lon_frac_q <= w_lon_frac_d;
      w_south_q    <= w_south_d;
      w_west_q     <= w_west_d;
      w_fix_q      <= w_fix_d;
      w_sats_q     <= w_sats_d;
      utc_q        <= utc_d;
      lat_q        <= lat_d;
      south_q      <= south_d;
      lon_q        <= lon_d;
      west_q       <= west_d;
      fix_q        <= fix_d;
      sats_q       <= sats_d;
      valid_q      <= valid_d;
      ck_err_q     <= ck_err_d;
      fr_err_q     <= fr_err_d;
    end
  end

endmodule
